// File: rtl/rf_wr_arbiter.sv
// Two-source arbiter for the register file write port: pipeline writeback (A) has
// priority, the long-latency unit (B) is forced through after STARVE_LIMIT stalls.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   S_NORMAL  | A has priority; B accepted only when A is idle
//   S_FORCE_B | B starved for STARVE_LIMIT cycles; A is held off for one slot
module rf_wr_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    output logic              starve_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STARVE_LIMIT);

    typedef enum logic {
        S_NORMAL,
        S_FORCE_B
    } state_t;

    state_t            state;
    state_t            state_nxt;
    // Stalled cycles B may still absorb before it is forced; terminal count is 1.
    logic [CNT_W-1:0]  starve_left;
    logic [CNT_W-1:0]  starve_left_nxt;
    logic              a_xfer;
    logic              b_xfer;

    assign a_xfer = a_valid && a_ready;
    assign b_xfer = b_valid && b_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_NORMAL;
            starve_left <= CNT_LOAD;
        end else begin
            state       <= state_nxt;
            starve_left <= starve_left_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        starve_left_nxt = starve_left;
        case (state)
            S_NORMAL: begin
                if (!b_valid || b_xfer) begin
                    starve_left_nxt = CNT_LOAD;
                end else if (starve_left == CNT_W'(1)) begin
                    state_nxt       = S_FORCE_B;
                    starve_left_nxt = CNT_LOAD;
                end else begin
                    starve_left_nxt = starve_left - CNT_W'(1);
                end
            end
            S_FORCE_B: begin
                // B is always ready here, so the slot is either used or B went idle.
                state_nxt       = S_NORMAL;
                starve_left_nxt = CNT_LOAD;
            end
            default: begin
                state_nxt       = S_NORMAL;
                starve_left_nxt = CNT_LOAD;
            end
        endcase
    end

    always_comb begin
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        starve_o = 1'b0;
        case (state)
            S_NORMAL: begin
                a_ready = 1'b1;
                b_ready = !a_valid;
            end
            S_FORCE_B: begin
                b_ready  = 1'b1;
                starve_o = 1'b1;
            end
            default: begin
                a_ready = 1'b0;
            end
        endcase
    end

    // x0 writes complete the handshake but never reach the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
        end else if (a_xfer && (a_rd != '0)) begin
            rf_we   <= 1'b1;
            rf_addr <= a_rd;
            rf_data <= a_data;
        end else if (b_xfer && (b_rd != '0)) begin
            rf_we   <= 1'b1;
            rf_addr <= b_rd;
            rf_data <= b_data;
        end else begin
            rf_we   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Scoreboarded bench for rf_wr_arbiter: directed scenarios plus compliant random traffic.
module tb_rf_wr_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int LIM    = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_rd;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_rd;
    logic [DATA_W-1:0] b_data;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic              starve_o;

    always #5 clk = ~clk;

    rf_wr_arbiter #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_rd    (a_rd),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_rd    (b_rd),
        .b_data  (b_data),
        .rf_we   (rf_we),
        .rf_addr (rf_addr),
        .rf_data (rf_data),
        .starve_o(starve_o)
    );

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    logic mf;
    int   mcnt;
    int   bwait;
    logic a_done;
    logic b_done;
    logic ea;
    logic eb;
    logic exp_now;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: predicts ready/starve and pushes the expected writes.
    initial begin
        mf = 1'b0; mcnt = 0; bwait = 0; a_done = 1'b0; b_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mf = 1'b0; mcnt = 0; bwait = 0; a_done = 1'b0; b_done = 1'b0;
            end else begin
                ea = !mf;
                eb = mf || !a_valid;
                chk("a_ready", 64'(a_ready), 64'(ea));
                chk("b_ready", 64'(b_ready), 64'(eb));
                chk("starve_o", 64'(starve_o), 64'(mf));
                chk("dual_xfer", 64'(a_valid && a_ready && b_valid && b_ready), 64'(0));
                a_done = a_valid && ea;
                b_done = b_valid && eb;
                if (a_done) begin
                    if (a_rd != '0) q.push_back('{cyc, a_rd, a_data});
                end else if (b_done) begin
                    if (b_rd != '0) q.push_back('{cyc, b_rd, b_data});
                end
                if (b_valid && !b_done) bwait++;
                else bwait = 0;
                if (b_valid) chk("b_wait", 64'(bwait <= LIM), 64'(1));
                if (mf) begin
                    mf = 1'b0; mcnt = 0;
                end else if (!b_valid || b_done) begin
                    mcnt = 0;
                end else begin
                    mcnt++;
                    if (mcnt == LIM) begin
                        mf = 1'b1; mcnt = 0;
                    end
                end
            end
        end
    end

    // Monitor: every write seen on rf_* must match the entry granted one cycle earlier.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_rf_we", 64'(rf_we), 64'(0));
                q.delete();
            end else begin
                exp_now = (q.size() > 0) && (q[0].cyc == cyc - 1);
                chk("rf_we", 64'(rf_we), 64'(exp_now));
                if (exp_now) begin
                    if (rf_we) begin
                        chk("rf_addr", 64'(rf_addr), 64'(q[0].addr));
                        chk("rf_data", 64'(rf_data), 64'(q[0].data));
                    end
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        a_valid = 1'b0; a_rd = '0; a_data = '0;
        b_valid = 1'b0; b_rd = '0; b_data = '0;
        repeat (2) tick();
        chk("reset_we", 64'(rf_we), 64'(0));
        chk("reset_addr", 64'(rf_addr), 64'(0));
        chk("reset_data", 64'(rf_data), 64'(0));
        chk("reset_starve", 64'(starve_o), 64'(0));
        rst_n = 1'b1;

        // A alone, rd=5
        tick();
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("t2_a_ready", 64'(a_ready), 64'(1));
        tick();
        a_valid = 1'b0;
        @(negedge clk);
        chk("t2_we", 64'(rf_we), 64'(1));
        chk("t2_addr", 64'(rf_addr), 64'(5));
        chk("t2_data", 64'(rf_data), 64'(32'hDEADBEEF));

        // Reset asserted between edges while a write is being presented
        tick();
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h0000_0333;
        @(posedge clk);
        #3;
        chk("t1_pre_rst_we", 64'(rf_we), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("t1_async_we", 64'(rf_we), 64'(0));
        chk("t1_async_addr", 64'(rf_addr), 64'(0));
        a_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("t1_idle_we", 64'(rf_we), 64'(0));
        end

        // Starvation: A saturating, B waiting
        tick();
        a_valid = 1'b1; a_rd = 5'd1; a_data = 32'hA0;
        b_valid = 1'b1; b_rd = 5'd9; b_data = 32'hB9;
        for (int i = 0; i < LIM; i++) begin
            @(negedge clk);
            chk("t3_a_grant", 64'({a_ready, b_ready, starve_o}), 64'(3'b100));
            tick();
        end
        @(negedge clk);
        chk("t3_force", 64'({a_ready, b_ready, starve_o}), 64'(3'b011));
        tick();
        b_valid = 1'b0;
        @(negedge clk);
        chk("t3_b_addr", 64'(rf_addr), 64'(9));
        chk("t3_b_data", 64'(rf_data), 64'(32'hB9));
        chk("t3_back_normal", 64'({a_ready, starve_o}), 64'(2'b10));
        tick();
        a_valid = 1'b0;

        // B alone writing x0
        tick();
        b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h1234;
        repeat (3) begin
            @(negedge clk);
            chk("t4_b_ready", 64'(b_ready), 64'(1));
            chk("t4_starve", 64'(starve_o), 64'(0));
            tick();
        end
        b_valid = 1'b0;
        @(negedge clk);
        chk("t4_we", 64'(rf_we), 64'(0));
        chk("t4_starve_end", 64'(starve_o), 64'(0));

        // Same rd from both sources: A first, B later wins
        tick();
        a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h1;
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h2;
        repeat (LIM) tick();
        a_valid = 1'b0;
        @(negedge clk);
        chk("t5_a_written", 64'({rf_we, rf_addr, rf_data}), 64'({1'b1, 5'd7, 32'h1}));
        chk("t5_force", 64'(starve_o), 64'(1));
        tick();
        b_valid = 1'b0;
        @(negedge clk);
        chk("t5_b_wins", 64'({rf_we, rf_addr, rf_data}), 64'({1'b1, 5'd7, 32'h2}));
        tick();

        // Random compliant traffic
        for (int c = 0; c < 10000; c++) begin
            if (!a_valid || a_done) begin
                a_valid = ($urandom_range(0, 99) < 60);
                a_rd    = ADDR_W'($urandom_range(0, 31));
                a_data  = $urandom;
            end
            if (!b_valid || b_done) begin
                b_valid = ($urandom_range(0, 99) < 50);
                b_rd    = ADDR_W'($urandom_range(0, 31));
                b_data  = $urandom;
            end
            tick();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (3) tick();
        chk("queue_drained", 64'(q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
